// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the parametrised sequence lock.
// Holds the FSM state encoding, the digit-width helper and the default code.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } lock_state_t;

  // Bits per code digit; a two-key pad still needs one bit.
  function automatic int kw(input int num_keys);
    return (num_keys <= 2) ? 1 : $clog2(num_keys);
  endfunction

  // Keys 0,2,3,1 with digit 0 in the LSBs.
  localparam logic [7:0] DEFAULT_CODE = 8'h78;

endpackage

// File: rtl/seq_lock_keypad.sv
// Button edge detector: turns debounced key levels into single presses.
// A press with more than one rising key is flagged invalid so it can never match.
module seq_lock_keypad #(
  parameter int NUM_KEYS = 4,
  parameter int KW       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic                press,
  output logic                valid,
  output logic [KW-1:0]       digit
);

  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= '0;
    else     key_q <= key;
  end

  assign rise  = key & ~key_q;
  assign press = |rise;
  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign valid = press && ((rise & (rise - NUM_KEYS'(1))) == '0);

  always_comb begin
    digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rise[i]) digit = KW'(i);
    end
  end

endmodule

// File: rtl/seq_lock.sv
// Sequence lock controller: collects CODE_LEN presses, checks them against a
// programmable code, and drives unlock pulse, fail pulse and timed lockout.
//
// state       | meaning
// ------------|---------------------------------------------------------
// ST_IDLE     | waiting for the first press of an attempt
// ST_ENTRY    | collecting presses; timeout counter running
// ST_UNLOCKED | unlock output high; code register writable
// ST_LOCKOUT  | too many failed attempts; all input ignored
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter  int NUM_KEYS       = 4,
  parameter  int CODE_LEN       = 4,
  localparam int KW             = kw(NUM_KEYS),
  parameter  logic [CODE_LEN*KW-1:0] RESET_CODE = DEFAULT_CODE,
  parameter  int MAX_FAILS      = 3,
  parameter  int TIMEOUT_CYCLES = 500,
  parameter  int LOCKOUT_CYCLES = 1000,
  parameter  int UNLOCK_CYCLES  = 8,
  localparam int CW             = $clog2(CODE_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_KEYS-1:0]    key,
  input  logic                   code_wr,
  input  logic [CODE_LEN*KW-1:0] code_data,
  output logic                   unlock,
  output logic                   fail,
  output logic                   locked_out,
  output logic                   busy,
  output logic [CW-1:0]          entry_cnt
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int UW = $clog2(UNLOCK_CYCLES + 1);

  localparam logic [CW-1:0] LAST_IDX  = CW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LO_LOAD   = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [UW-1:0] UL_LOAD   = UW'(UNLOCK_CYCLES - 1);

  logic          press, valid;
  logic [KW-1:0] digit;

  seq_lock_keypad #(.NUM_KEYS(NUM_KEYS), .KW(KW)) u_keypad (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .press (press),
    .valid (valid),
    .digit (digit)
  );

  lock_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mm_q, mm_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [CODE_LEN*KW-1:0] code_q, code_d;
  logic [TW-1:0]        to_q, to_d;
  logic [LW-1:0]        lo_q, lo_d;
  logic [UW-1:0]        ul_q, ul_d;
  logic                 fail_d;
  logic                 unlock_q, fail_q, locked_out_q, busy_q;

  logic                 dig_mm, mm_new, done;

  // Timers count down to their terminal value of zero and hold there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mm_d    = mm_q;
    fcnt_d  = fcnt_q;
    code_d  = code_q;
    to_d    = (to_q != '0) ? to_q - TW'(1) : to_q;
    lo_d    = (lo_q != '0) ? lo_q - LW'(1) : lo_q;
    ul_d    = (ul_q != '0) ? ul_q - UW'(1) : ul_q;
    fail_d  = 1'b0;
    done    = 1'b0;
    mm_new  = 1'b0;
    dig_mm  = !valid || (digit != code_q[int'(cnt_q)*KW +: KW]);

    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          mm_new = dig_mm;
          if (CODE_LEN == 1) begin
            done = 1'b1;
          end else begin
            state_d = ST_ENTRY;
            cnt_d   = CW'(1);
            mm_d    = mm_new;
            to_d    = TO_LOAD;
          end
        end
      end
      ST_ENTRY: begin
        if (press) begin
          mm_new = mm_q | dig_mm;
          if (cnt_q == LAST_IDX) begin
            done = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            mm_d  = mm_new;
            to_d  = TO_LOAD;
          end
        end else if (to_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mm_d    = 1'b0;
        end
      end
      ST_UNLOCKED: begin
        if (code_wr) code_d = code_data;
        if (ul_q == '0) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (lo_q == '0) begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      cnt_d = '0;
      mm_d  = 1'b0;
      if (!mm_new) begin
        state_d = ST_UNLOCKED;
        fcnt_d  = '0;
        ul_d    = UL_LOAD;
      end else begin
        fail_d = 1'b1;
        fcnt_d = fcnt_q + FW'(1);
        if (fcnt_q == FAIL_LAST) begin
          state_d = ST_LOCKOUT;
          lo_d    = LO_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mm_q         <= 1'b0;
      fcnt_q       <= '0;
      code_q       <= RESET_CODE;
      to_q         <= '0;
      lo_q         <= '0;
      ul_q         <= '0;
      unlock_q     <= 1'b0;
      fail_q       <= 1'b0;
      locked_out_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mm_q         <= mm_d;
      fcnt_q       <= fcnt_d;
      code_q       <= code_d;
      to_q         <= to_d;
      lo_q         <= lo_d;
      ul_q         <= ul_d;
      unlock_q     <= (state_d == ST_UNLOCKED);
      fail_q       <= fail_d;
      locked_out_q <= (state_d == ST_LOCKOUT);
      busy_q       <= (state_d == ST_ENTRY);
    end
  end

  assign unlock     = unlock_q;
  assign fail       = fail_q;
  assign locked_out = locked_out_q;
  assign busy       = busy_q;
  assign entry_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_lock.sv
// Directed bench for seq_lock with short timers (timeout 16, lockout 32, unlock 4).
module tb_seq_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       code_wr;
  logic [7:0] code_data;
  logic       unlock, fail, locked_out, busy;
  logic [2:0] entry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lo_start;

  seq_lock #(
    .NUM_KEYS(4), .CODE_LEN(4), .RESET_CODE(8'h78), .MAX_FAILS(3),
    .TIMEOUT_CYCLES(16), .LOCKOUT_CYCLES(32), .UNLOCK_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .code_wr(code_wr), .code_data(code_data),
    .unlock(unlock), .fail(fail), .locked_out(locked_out), .busy(busy),
    .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k);
    key = 4'b0001 << k;
    tick();
    key = '0;
  endtask

  // Leaves the bench just after the edge that samples the final press.
  task automatic enter_code(input logic [7:0] code);
    for (int i = 0; i < 4; i++) begin
      press_key(int'(code[2*i +: 2]));
      if (i < 3) tick();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((unlock || locked_out || busy) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_idle", int'(n < 200), 1);
  endtask

  initial begin
    rst = 1'b1; key = '0; code_wr = 1'b0; code_data = '0;
    tick(); tick();
    chk("rst_unlock", unlock, 0);
    chk("rst_fail", fail, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", entry_cnt, 0);
    #2 rst = 1'b0;

    // correct code
    press_key(0);
    chk("first_busy", busy, 1);
    chk("first_cnt", entry_cnt, 1);
    tick(); press_key(2);
    chk("second_cnt", entry_cnt, 2);
    tick(); press_key(3);
    tick(); press_key(1);
    for (int i = 0; i < 4; i++) begin
      chk("unlock_on", unlock, 1);
      chk("unlock_nofail", fail, 0);
      tick();
    end
    chk("unlock_off", unlock, 0);
    chk("unlock_busy", busy, 0);

    // three wrong attempts -> lockout
    for (int a = 0; a < 3; a++) begin
      enter_code(8'h38);
      chk("wrong_fail", fail, 1);
      chk("wrong_locked", locked_out, int'(a == 2));
      chk("wrong_cnt", entry_cnt, 0);
      if (a == 2) lo_start = cyc;
      tick();
      chk("fail_pulse_end", fail, 0);
    end
    enter_code(8'h78);
    chk("lockout_ignore", unlock, 0);
    chk("lockout_hold", locked_out, 1);
    begin
      int n = 0;
      while (locked_out && n < 200) begin
        tick();
        n++;
      end
    end
    chk("lockout_len", cyc - lo_start, 32);

    // fail count cleared by lockout exit: one wrong attempt does not lock out
    enter_code(8'h38);
    chk("post_lo_fail", fail, 1);
    chk("post_lo_locked", locked_out, 0);
    tick();

    // timeout with fail_cnt = 1
    press_key(0); tick(); press_key(2);
    repeat (15) tick();
    chk("to_busy_before", busy, 1);
    chk("to_cnt_before", entry_cnt, 2);
    tick();
    chk("to_busy_after", busy, 0);
    chk("to_cnt_after", entry_cnt, 0);
    chk("to_nofail", fail, 0);
    enter_code(8'h38);
    chk("to_fail2_locked", locked_out, 0);
    tick();
    enter_code(8'h38);
    chk("to_fail3_locked", locked_out, 1);
    wait_idle();
    enter_code(8'h78);
    chk("after_to_unlock", unlock, 1);
    wait_idle();

    // simultaneous keys as first press
    key = 4'b0011;
    tick();
    chk("multi_busy", busy, 1);
    chk("multi_cnt", entry_cnt, 1);
    key = '0;
    tick(); press_key(2);
    tick(); press_key(3);
    chk("multi_cnt3", entry_cnt, 3);
    tick(); press_key(1);
    chk("multi_fail", fail, 1);
    chk("multi_unlock", unlock, 0);
    tick();

    // code_wr in IDLE ignored, then reprogram while unlocked
    code_data = 8'h1B; code_wr = 1'b1;
    tick();
    code_wr = 1'b0;
    enter_code(8'h78);
    chk("idle_wr_ignored", unlock, 1);
    code_wr = 1'b1;
    tick();
    code_wr = 1'b0;
    wait_idle();
    enter_code(8'h1B);
    chk("new_code_unlock", unlock, 1);
    wait_idle();
    enter_code(8'h78);
    chk("old_code_fail", fail, 1);
    chk("old_code_unlock", unlock, 0);
    tick();
    wait_idle();

    // reset on the second unlock cycle
    enter_code(8'h1B);
    chk("pre_rst_unlock", unlock, 1);
    tick();
    chk("unlock_cycle2", unlock, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_unlock", unlock, 0);
    #2 rst = 1'b0;
    enter_code(8'h78);
    chk("rst_code_revert", unlock, 1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
